// File: rtl/shift_bits_right_seq.sv
// Sequential right-rotator: captures a word and a step count, rotates one bit
// per clock, then publishes the result with a single-cycle listo pulse.
module shift_bits_right_seq #(
    parameter int ANCHO = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inicio,
    input  logic [ANCHO-1:0] entrada,
    input  logic [2:0]       cantidad,
    output logic [ANCHO-1:0] salida,
    output logic             ocupado,
    output logic             listo
);

    typedef enum logic [1:0] {
        REPOSO  = 2'd0,
        ROTANDO = 2'd1,
        FIN     = 2'd2
    } t_estado;

    t_estado          r_estado;
    logic [ANCHO-1:0] r_dato;
    logic [2:0]       r_cuenta;
    logic [ANCHO-1:0] r_salida;
    logic             r_ocupado;
    logic             r_listo;

    // Bit 0 wraps to the MSB; every other bit moves down one place.
    function automatic logic [ANCHO-1:0] f_rot_der(input logic [ANCHO-1:0] v);
        return {v[0], v[ANCHO-1:1]};
    endfunction

    // Control FSM, datapath and registered outputs in one clocked process.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_estado  <= REPOSO;
            r_dato    <= {ANCHO{1'b0}};
            r_cuenta  <= 3'd0;
            r_salida  <= {ANCHO{1'b0}};
            r_ocupado <= 1'b0;
            r_listo   <= 1'b0;
        end else begin
            case (r_estado)
                REPOSO: begin
                    if (inicio) begin
                        r_dato    <= entrada;
                        r_cuenta  <= cantidad;
                        r_ocupado <= 1'b1;
                        r_listo   <= 1'b0;
                        r_estado  <= ROTANDO;
                    end else begin
                        r_listo   <= 1'b0;
                        r_estado  <= REPOSO;
                    end
                end
                ROTANDO: begin
                    // The count is used as-is; wrap-around falls out of the rotation.
                    if (r_cuenta != 3'd0) begin
                        r_dato   <= f_rot_der(r_dato);
                        r_cuenta <= r_cuenta - 3'd1;
                        r_estado <= ROTANDO;
                    end else begin
                        r_salida <= r_dato;
                        r_listo  <= 1'b1;
                        r_estado <= FIN;
                    end
                end
                FIN: begin
                    r_listo   <= 1'b0;
                    r_ocupado <= 1'b0;
                    r_estado  <= REPOSO;
                end
                default: begin
                    r_listo   <= 1'b0;
                    r_ocupado <= 1'b0;
                    r_estado  <= REPOSO;
                end
            endcase
        end
    end

    assign salida  = r_salida;
    assign ocupado = r_ocupado;
    assign listo   = r_listo;

endmodule

// File: tb/tb_shift_bits_right_seq.sv
// Self-checking bench for shift_bits_right_seq: directed corner cases, random
// operations and a left-rotate round trip, all against an arithmetic model.
module tb_shift_bits_right_seq;

    localparam int W = 5;

    logic         clk = 1'b0;
    logic         reset;
    logic         inicio;
    logic [W-1:0] entrada;
    logic [2:0]   cantidad;
    logic [W-1:0] salida;
    logic         ocupado;
    logic         listo;

    int           n_cmp = 0;
    int           n_bad = 0;
    logic [W-1:0] m_salida;

    shift_bits_right_seq #(.ANCHO(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .inicio   (inicio),
        .entrada  (entrada),
        .cantidad (cantidad),
        .salida   (salida),
        .ocupado  (ocupado),
        .listo    (listo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Rotation right by c places, computed arithmetically on the value.
    function automatic logic [W-1:0] ref_rotr(input logic [W-1:0] x, input int c);
        int k;
        int v;
        k = c % W;
        v = int'(x);
        if (k == 0) return x;
        return W'(((v >> k) | (v << (W - k))) & ((1 << W) - 1));
    endfunction

    function automatic logic [W-1:0] rotl1(input logic [W-1:0] x);
        return {x[W-2:0], x[W-1]};
    endfunction

    // One complete operation with timing, pulse and hold checks.
    task automatic run_op(input string tag, input logic [W-1:0] e, input logic [2:0] c,
                          input bit intrude, output logic [W-1:0] got);
        int           first_listo;
        int           n_listo;
        int           n_busy;
        int           n_ocup;
        bit           stable;
        logic [W-1:0] exp_r;
        exp_r = ref_rotr(e, int'(c));
        @(negedge clk);
        entrada  = e;
        cantidad = c;
        inicio   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        inicio   = 1'b0;
        entrada  = ~e;
        cantidad = c + 3'd3;
        first_listo = -1;
        n_listo = 0;
        n_busy  = 0;
        n_ocup  = 0;
        stable  = 1'b1;
        got     = '0;
        for (int k = 0; k < int'(c) + 6; k++) begin
            if (k > 0) @(negedge clk);
            if (intrude && k == 1) begin
                inicio   = 1'b1;
                entrada  = e ^ 5'b10101;
                cantidad = 3'd1;
            end else if (intrude && k == 2) begin
                inicio = 1'b0;
            end
            if (listo) begin
                n_listo++;
                if (first_listo < 0) begin
                    first_listo = k;
                    got = salida;
                end
            end
            if (ocupado) n_ocup++;
            if (ocupado && !listo) n_busy++;
            if (first_listo < 0 && salida !== m_salida) stable = 1'b0;
        end
        chk({tag, " listo latency"}, first_listo, int'(c) + 1);
        chk({tag, " listo pulses"}, n_listo, 1);
        chk({tag, " busy before listo"}, n_busy, int'(c) + 1);
        chk({tag, " ocupado total"}, n_ocup, int'(c) + 2);
        chk({tag, " salida"}, got, exp_r);
        chk({tag, " salida stable before done"}, stable, 1);
        chk({tag, " salida held"}, salida, exp_r);
        m_salida = exp_r;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] got;
        logic [W-1:0] rt;
        int           p1;
        int           p2;
        int           n_late;
        bit           zero_hold;

        reset    = 1'b1;
        inicio   = 1'b0;
        entrada  = '0;
        cantidad = 3'd0;
        m_salida = '0;
        repeat (2) @(negedge clk);
        chk("reset salida", salida, 0);
        chk("reset ocupado", ocupado, 0);
        chk("reset listo", listo, 0);
        reset = 1'b0;

        run_op("r026", 5'b00001, 3'd1, 1'b0, got);
        run_op("r027", 5'b10110, 3'd2, 1'b0, got);
        run_op("r028 c0", 5'b11010, 3'd0, 1'b0, got);
        run_op("r028 c5", 5'b11010, 3'd5, 1'b0, got);
        chk("r028 c5 identity", got, 5'b11010);
        run_op("r028 c2", 5'b11010, 3'd2, 1'b0, got);
        rt = got;
        run_op("r028 c7", 5'b11010, 3'd7, 1'b0, got);
        chk("r028 c7 equals c2", got, rt);
        run_op("r029 intrude", 5'b00111, 3'd4, 1'b1, got);
        run_op("pre-reset", 5'b10110, 3'd1, 1'b0, got);

        // Abort an operation with reset in its second rotating cycle.
        @(negedge clk);
        entrada  = 5'b10110;
        cantidad = 3'd4;
        inicio   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        inicio = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("r030 busy before reset", ocupado, 1);
        reset = 1'b1;
        #1;
        chk("r030 ocupado", ocupado, 0);
        chk("r030 listo", listo, 0);
        chk("r030 salida", salida, 0);
        @(negedge clk);
        reset = 1'b0;
        n_late = 0;
        zero_hold = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (listo) n_late++;
            if (salida !== 5'b00000) zero_hold = 1'b0;
        end
        chk("r030 no late listo", n_late, 0);
        chk("r030 salida stays 0", zero_hold, 1);
        m_salida = '0;

        run_op("r025 after reset", 5'b01101, 3'd3, 1'b0, got);

        // inicio held high: starts repeat every cantidad+3 cycles.
        @(negedge clk);
        entrada  = 5'b01011;
        cantidad = 3'd2;
        inicio   = 1'b1;
        p1 = -1;
        p2 = -1;
        for (int k = 0; k < 40 && p2 < 0; k++) begin
            @(negedge clk);
            if (listo) begin
                if (p1 < 0) p1 = k;
                else        p2 = k;
            end
        end
        inicio = 1'b0;
        chk("r021 start spacing", p2 - p1, 5);
        chk("r021 salida", salida, ref_rotr(5'b01011, 2));
        repeat (8) @(negedge clk);
        m_salida = ref_rotr(5'b01011, 2);

        for (int i = 0; i < 16; i++) begin
            run_op("rand", 5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)), 1'b0, got);
        end

        for (int e = 0; e < 32; e++) begin
            for (int c = 1; c <= 4; c++) begin
                run_op("rt", 5'(e), 3'(c), 1'b0, got);
                rt = got;
                for (int j = 0; j < c; j++) rt = rotl1(rt);
                chk("r031 roundtrip", rt, e);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
